// File: rtl/lcd_spectrum_render_if.sv
// Bus between the LCD driver / FFT post-processing side and the spectrum renderer.
// The master drives pixel coordinates, frame sync and bin writes; the slave
// (renderer) returns the pixel colour and the load handshake.
interface lcd_spectrum_render_if #(
  parameter int IDX_W = 7
);
  logic             frame_sync;
  logic [10:0]      pixel_xpos;
  logic [10:0]      pixel_ypos;
  logic [15:0]      pixel_data;
  logic [IDX_W-1:0] line_cnt;
  logic [15:0]      line_length;
  logic             line_wr;
  logic             data_req;
  logic             wr_over;

  modport master (
    output frame_sync, pixel_xpos, pixel_ypos, line_cnt, line_length, line_wr,
    input  pixel_data, data_req, wr_over
  );

  modport slave (
    input  frame_sync, pixel_xpos, pixel_ypos, line_cnt, line_length, line_wr,
    output pixel_data, data_req, wr_over
  );
endinterface

// File: rtl/lcd_spectrum_render.sv
// Spectrum-bar renderer: stores one scaled height per bin in a double-buffered
// memory (back bank written, front bank displayed, swapped on frame_sync once a
// set is complete) and returns an RGB565 colour per presented pixel, one cycle
// after the coordinate.
// Optional feature macro: SPECTRUM_PEAK_HOLD_EN adds per-bar decaying peak markers.
module lcd_spectrum_render #(
  parameter int          H_DISP     = 800,
  parameter int          V_DISP     = 480,
  parameter int          BARS       = 128,
  parameter int          IDX_W      = 7,
  parameter int          BAR_W      = 5,
  parameter int          BAR_GAP    = 1,
  parameter int          SCALE_SH   = 6,
  parameter logic [15:0] BAR_COLOR  = 16'h07E0,
  parameter logic [15:0] BG_COLOR   = 16'h0000,
  parameter logic [15:0] PEAK_COLOR = 16'hF800,
  parameter int          PEAK_H     = 2,
  parameter int          PEAK_DECAY = 4
) (
  input  logic                  lcd_clk,
  input  logic                  sys_rst,
  lcd_spectrum_render_if.slave  bus
);

  localparam int P  = BAR_W + BAR_GAP;
  localparam int HW = $clog2(V_DISP + 1);
  localparam int IW = (BARS > 1) ? $clog2(BARS) : 1;
  localparam int BW = IW + 1;
  localparam int CW = (P > 1) ? $clog2(P) : 1;

  localparam logic [15:0]      V_DISP_16 = 16'(V_DISP);
  localparam logic [HW-1:0]    V_DISP_H  = HW'(V_DISP);
  localparam logic [11:0]      V_DISP_12 = 12'(V_DISP);
  localparam logic [10:0]      H_DISP_11 = 11'(H_DISP);
  localparam logic [10:0]      V_DISP_11 = 11'(V_DISP);
  localparam logic [IDX_W:0]   BARS_IDX  = (IDX_W + 1)'(BARS);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(BARS - 1);
  localparam logic [BW-1:0]    BARS_BW   = BW'(BARS);
  localparam logic [CW-1:0]    COL_LAST  = CW'(P - 1);
  localparam logic [CW:0]      BAR_W_C   = (CW + 1)'(BAR_W);
  localparam logic [11:0]      PEAK_H_12 = 12'(PEAK_H);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_DONE} state_t;

  state_t         state_q, state_d;
  logic           front_q, front_d;
  logic [1:0]     valid_q, valid_d;
  logic           wr_over_q, wr_over_d;
  logic [15:0]    pixel_data_q, pixel_data_d;
  logic [10:0]    x_prev_q, x_prev_d;
  logic [CW-1:0]  col_q, col_d;
  logic [BW-1:0]  bar_q, bar_d;

  logic           back_sel;
  logic           wr_accept;
  logic           last_write;
  logic           swap;
  logic [15:0]    scaled;
  logic [HW-1:0]  height_new;
  logic [IW-1:0]  bar_idx;
  logic [HW-1:0]  h_cur;
  logic [HW-1:0]  pk_cur;
  logic           in_col;
  logic [11:0]    y_12;
  logic [11:0]    bar_top;
  logic [11:0]    pk_top;

  logic [HW-1:0]  height_mem [2][BARS];

  assign back_sel = ~front_q;

  // Scale and clamp the incoming magnitude, and qualify the write strobe
  always_comb begin
    scaled     = bus.line_length >> SCALE_SH;
    height_new = (scaled > V_DISP_16) ? V_DISP_H : scaled[HW-1:0];
    wr_accept  = !sys_rst && (state_q == ST_REQ) && bus.line_wr &&
                 ({1'b0, bus.line_cnt} < BARS_IDX);
    last_write = wr_accept && (bus.line_cnt == LAST_IDX);
  end

  // Load FSM state register
  always_ff @(posedge lcd_clk) begin
    if (sys_rst) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Load FSM next state: swap only when a complete set waits in the back bank
  always_comb begin
    state_d   = state_q;
    swap      = 1'b0;
    wr_over_d = 1'b0;
    case (state_q)
      ST_IDLE: if (bus.frame_sync) state_d = ST_REQ;
      ST_REQ: begin
        if (last_write) begin
          state_d   = ST_DONE;
          wr_over_d = 1'b1;
        end
      end
      ST_DONE: begin
        if (bus.frame_sync && !sys_rst) begin
          state_d = ST_REQ;
          swap    = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    front_d = swap ? back_sel : front_q;
    valid_d = valid_q;
    if (swap) valid_d[back_sel] = 1'b1;
  end

  // Load FSM outputs
  always_comb begin
    bus.data_req   = (state_q == ST_REQ);
    bus.wr_over    = wr_over_q;
    bus.pixel_data = pixel_data_q;
  end

  // Bin writes land in the back bank; no reset, valid flags gate visibility
  always_ff @(posedge lcd_clk) begin
    if (wr_accept) height_mem[back_sel][bus.line_cnt[IW-1:0]] <= height_new;
  end

  // Column/bar counters follow the driver's x scan, restarting at column 0
  always_comb begin
    x_prev_d = bus.pixel_xpos;
    col_d    = col_q;
    bar_d    = bar_q;
    if (bus.pixel_xpos == 11'd0) begin
      col_d = '0;
      bar_d = '0;
    end else if (bus.pixel_xpos != x_prev_q) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        if (bar_q != BARS_BW) bar_d = bar_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

`ifdef SPECTRUM_PEAK_HOLD_EN
  localparam logic [HW-1:0] DECAY_H = HW'(PEAK_DECAY);

  logic [HW-1:0] peak_q [BARS];
  logic [HW-1:0] peak_d [BARS];
  logic          peak_valid_q, peak_valid_d;

  function automatic logic [HW-1:0] peak_next(input logic [HW-1:0] h_new,
                                              input logic [HW-1:0] pk_old,
                                              input logic          pk_valid);
    logic [HW-1:0] dec;
    dec = (pk_valid && (pk_old > DECAY_H)) ? (pk_old - DECAY_H) : '0;
    return (h_new > dec) ? h_new : dec;
  endfunction

  // Fold the bank being promoted into the decaying peak memory at each swap
  always_comb begin
    peak_valid_d = peak_valid_q | swap;
    for (int k = 0; k < BARS; k++) begin
      peak_d[k] = peak_q[k];
      if (swap) peak_d[k] = peak_next(height_mem[back_sel][IW'(k)], peak_q[k], peak_valid_q);
    end
  end

  // Peak memory is cleared lazily: contents ignored until the first swap
  always_ff @(posedge lcd_clk) begin
    if (sys_rst) peak_valid_q <= 1'b0;
    else         peak_valid_q <= peak_valid_d;
    peak_q <= peak_d;
  end

  assign pk_cur = peak_q[bar_idx];
`else
  assign pk_cur = '0;
`endif

  // Pixel colour for the presented coordinate from the front bank
  always_comb begin
    bar_idx      = bar_d[IW-1:0];
    h_cur        = height_mem[front_q][bar_idx];
    y_12         = {1'b0, bus.pixel_ypos};
    bar_top      = V_DISP_12 - 12'(h_cur);
    pk_top       = V_DISP_12 - 12'(pk_cur);
    in_col       = valid_q[front_q] && (bar_d < BARS_BW) && ({1'b0, col_d} < BAR_W_C) &&
                   (bus.pixel_xpos < H_DISP_11) && (bus.pixel_ypos < V_DISP_11);
    pixel_data_d = BG_COLOR;
    if (in_col && (h_cur != '0) && (y_12 >= bar_top)) pixel_data_d = BAR_COLOR;
    if (in_col && (pk_cur != '0) && (y_12 >= pk_top) && (y_12 < pk_top + PEAK_H_12))
      pixel_data_d = PEAK_COLOR;
  end

  // Bank control, handshake pulse, render counters and registered colour
  always_ff @(posedge lcd_clk) begin
    if (sys_rst) begin
      front_q      <= 1'b0;
      valid_q      <= 2'b00;
      wr_over_q    <= 1'b0;
      pixel_data_q <= 16'h0000;
      x_prev_q     <= 11'd0;
      col_q        <= '0;
      bar_q        <= '0;
    end else begin
      front_q      <= front_d;
      valid_q      <= valid_d;
      wr_over_q    <= wr_over_d;
      pixel_data_q <= pixel_data_d;
      x_prev_q     <= x_prev_d;
      col_q        <= col_d;
      bar_q        <= bar_d;
    end
  end

endmodule

// File: tb/tb_lcd_spectrum_render.sv
// Scoreboard bench for lcd_spectrum_render: row scans push expected colours,
// a negedge monitor pops and compares the registered pixel one cycle later.
module tb_lcd_spectrum_render;
  localparam int H_DISP = 800;
  localparam int V_DISP = 480;
  localparam int BARS   = 128;
  localparam int IDX_W  = 7;
  localparam int P      = 6;
  localparam int BAR_W  = 5;
  localparam logic [15:0] BG   = 16'h0000;
  localparam logic [15:0] BAR  = 16'h07E0;
  localparam logic [15:0] PEAK = 16'hF800;

  typedef struct {
    int          x;
    int          y;
    logic [15:0] pix;
  } exp_t;

  logic lcd_clk = 1'b0;
  logic sys_rst = 1'b1;
  lcd_spectrum_render_if #(.IDX_W(IDX_W)) bus ();

  lcd_spectrum_render dut (
    .lcd_clk (lcd_clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  always #5 lcd_clk = ~lcd_clk;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   wr_over_seen = 0;
  exp_t exp_q[$];
  logic coord_valid = 1'b0;
  logic pix_pending = 1'b0;
  int   exp_h  [BARS];
  int   exp_pk [BARS];
  bit   exp_valid = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_bad++;
      $display("[TB] FAIL %s: got 'h%0h expected 'h%0h", name, actual, expected);
    end
  endtask

  function automatic logic [15:0] expPixel(input int x, input int y);
    int k, c;
    logic [15:0] col;
    col = BG;
    if (!exp_valid || x >= H_DISP || y >= V_DISP) return BG;
    k = x / P;
    c = x % P;
    if (k >= BARS || c >= BAR_W) return BG;
    if (exp_h[k] > 0 && y >= V_DISP - exp_h[k]) col = BAR;
    if (exp_pk[k] > 0 && y >= V_DISP - exp_pk[k] && y < V_DISP - exp_pk[k] + 2) col = PEAK;
    return col;
  endfunction

  always @(posedge lcd_clk) pix_pending <= coord_valid;

  always @(negedge lcd_clk) begin
    exp_t e;
    if (bus.wr_over === 1'b1) wr_over_seen++;
    if (pix_pending) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("[TB] FAIL scoreboard_underflow: got pixel 'h%0h with no expected entry", bus.pixel_data);
      end else begin
        e = exp_q.pop_front();
        checkOutput($sformatf("pixel(%0d,%0d)", e.x, e.y), 32'(bus.pixel_data), 32'(e.pix));
      end
    end
  end

  task automatic applyStimulus(input int y, input int n, input bit in_reset);
    exp_t e;
    for (int x = 0; x < n; x++) begin
      @(negedge lcd_clk);
      bus.pixel_xpos = 11'(x);
      bus.pixel_ypos = 11'(y);
      coord_valid    = 1'b1;
      e.x = x;
      e.y = y;
      e.pix = in_reset ? 16'h0000 : expPixel(x, y);
      exp_q.push_back(e);
    end
    @(negedge lcd_clk);
    coord_valid    = 1'b0;
    bus.pixel_xpos = 11'd0;
    @(negedge lcd_clk);
  endtask

  task automatic scanRow(input int y);
    applyStimulus(y, H_DISP + 4, 1'b0);
  endtask

  task automatic writeBin(input int idx, input int len);
    @(negedge lcd_clk);
    bus.line_wr     = 1'b1;
    bus.line_cnt    = IDX_W'(idx);
    bus.line_length = 16'(len);
  endtask

  task automatic endWrites(input string name, input logic exp_over);
    @(negedge lcd_clk);
    bus.line_wr = 1'b0;
    checkOutput(name, 32'(bus.wr_over), 32'(exp_over));
  endtask

  task automatic frameSync();
    @(negedge lcd_clk);
    bus.frame_sync = 1'b1;
    @(negedge lcd_clk);
    bus.frame_sync = 1'b0;
  endtask

  initial begin
    bus.frame_sync  = 1'b0;
    bus.pixel_xpos  = 11'd0;
    bus.pixel_ypos  = 11'd0;
    bus.line_cnt    = '0;
    bus.line_length = 16'd0;
    bus.line_wr     = 1'b0;
    for (int k = 0; k < BARS; k++) begin
      exp_h[k]  = 0;
      exp_pk[k] = 0;
    end

    $display("[TB] reset and blank frame");
    applyStimulus(100, 40, 1'b1);
    checkOutput("data_req_in_reset", 32'(bus.data_req), 32'd0);
    checkOutput("wr_over_in_reset", 32'(bus.wr_over), 32'd0);
    @(negedge lcd_clk);
    sys_rst = 1'b0;
    scanRow(0);
    scanRow(240);
    scanRow(479);
    scanRow(480);
    checkOutput("data_req_before_sync", 32'(bus.data_req), 32'd0);

    $display("[TB] first full set, height 100");
    frameSync();
    checkOutput("data_req_rise", 32'(bus.data_req), 32'd1);
    for (int k = 0; k < BARS; k++) writeBin(k, 64 * 100);
    endWrites("wr_over_first_set", 1'b1);
    checkOutput("data_req_fall", 32'(bus.data_req), 32'd0);
    @(negedge lcd_clk);
    checkOutput("wr_over_single_pulse", 32'(bus.wr_over), 32'd0);
    scanRow(479);
    frameSync();
    checkOutput("data_req_after_swap", 32'(bus.data_req), 32'd1);
    exp_valid = 1'b1;
    for (int k = 0; k < BARS; k++) exp_h[k] = 100;
    scanRow(379);
    scanRow(380);
    scanRow(479);
    scanRow(480);
    checkOutput("wr_over_count_1", 32'(wr_over_seen), 32'd1);

    $display("[TB] clamp and zero-height bins");
    writeBin(3, 16'hFFFF);
    for (int k = 0; k < BARS; k++) writeBin(k, (k == 0) ? 16'hFFFF : (k == 1) ? 63 : 64 * 100);
    endWrites("wr_over_clamp_set", 1'b1);
    frameSync();
    exp_h[0] = 480;
    exp_h[1] = 0;
    scanRow(0);
    scanRow(380);
    scanRow(479);
    checkOutput("wr_over_count_2", 32'(wr_over_seen), 32'd2);

    $display("[TB] incomplete set, no swap");
    for (int k = 0; k < BARS - 1; k++) writeBin(k, 64 * 200);
    endWrites("wr_over_partial", 1'b0);
    frameSync();
    checkOutput("data_req_partial_hold", 32'(bus.data_req), 32'd1);
    scanRow(290);
    writeBin(127, 64 * 200);
    endWrites("wr_over_completed", 1'b1);
    writeBin(5, 0);
    writeBin(127, 0);
    endWrites("wr_over_done_ignored", 1'b0);
    checkOutput("data_req_in_done", 32'(bus.data_req), 32'd0);
    frameSync();
    for (int k = 0; k < BARS; k++) exp_h[k] = 200;
    scanRow(279);
    scanRow(280);
    checkOutput("wr_over_count_3", 32'(wr_over_seen), 32'd3);

    $display("[TB] reset during load");
    writeBin(0, 0);
    writeBin(1, 0);
    @(negedge lcd_clk);
    bus.line_wr = 1'b0;
    sys_rst     = 1'b1;
    applyStimulus(300, 20, 1'b1);
    checkOutput("data_req_mid_reset", 32'(bus.data_req), 32'd0);
    @(negedge lcd_clk);
    sys_rst   = 1'b0;
    exp_valid = 1'b0;
    scanRow(479);
    frameSync();
    checkOutput("data_req_after_reset_sync", 32'(bus.data_req), 32'd1);
    checkOutput("wr_over_count_4", 32'(wr_over_seen), 32'd3);

`ifdef SPECTRUM_PEAK_HOLD_EN
    $display("[TB] peak hold decay");
    for (int k = 0; k < BARS; k++) writeBin(k, (k == 0) ? 64 * 200 : 0);
    endWrites("wr_over_peak_1", 1'b1);
    frameSync();
    exp_valid = 1'b1;
    for (int k = 0; k < BARS; k++) exp_h[k] = 0;
    exp_h[0]  = 200;
    exp_pk[0] = 200;
    scanRow(279);
    scanRow(280);
    scanRow(281);
    scanRow(282);
    for (int k = 0; k < BARS; k++) writeBin(k, 0);
    endWrites("wr_over_peak_2", 1'b1);
    frameSync();
    exp_h[0]  = 0;
    exp_pk[0] = 196;
    scanRow(283);
    scanRow(284);
    scanRow(285);
    scanRow(286);
    for (int k = 0; k < BARS; k++) writeBin(k, 0);
    endWrites("wr_over_peak_3", 1'b1);
    frameSync();
    exp_pk[0] = 192;
    scanRow(288);
`endif

    repeat (4) @(negedge lcd_clk);
    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
